// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse_capture block: FSM state encoding.
package pulse_capture_pkg;

  // Measurement FSM states (plain constants so older blocks can share them).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

endpackage : pulse_capture_pkg

// File: rtl/pulse_capture_sync_edge_detect.sv
// Synchronizes an asynchronous pin and produces registered one-cycle rise/fall
// pulses. A transition on d_async shows up as a rise/fall pulse SYNC_STAGES+1
// clocks later. SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, previous-level flop and registered edge pulses.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule : sync_edge_detect

// File: rtl/pulse_capture.sv
// Measures period (rise to rise) and high time (rise to first fall) of an
// external signal in clk cycles. Results are offered through a valid/ready
// hold register; a result that completes while an unread one is held is
// discarded and flagged with the sticky dropped bit.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overflow,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             dropped
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             rise;
  logic             fall;
  // Only edges matter for timing; the synchronized level is not consumed here.
  logic             level_unused;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic             hi_seen_q, hi_seen_d;

  logic             done;
  logic [WIDTH-1:0] done_period;
  logic [WIDTH-1:0] done_high;
  logic             done_ovf;

  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_time_q;
  logic             overflow_q;
  logic             valid_q;
  logic             dropped_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_async (sig_in),
    .level   (level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  // Next-state logic for the FSM, saturating counter and high-time capture.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    hi_seen_d   = hi_seen_q;
    done        = 1'b0;
    done_period = cnt_q;
    done_high   = hi_cap_q;
    done_ovf    = 1'b0;

    if (!enable) begin
      // Abort: any partial measurement is dropped, the held result is kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;

        ST_ARM: begin
          if (rise) begin
            cnt_d     = CNT_ONE;
            hi_cap_d  = '0;
            hi_seen_d = 1'b0;
            state_d   = ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (rise) begin
            // A rise beats simultaneous saturation: normal result.
            done      = 1'b1;
            cnt_d     = CNT_ONE;
            hi_cap_d  = '0;
            hi_seen_d = 1'b0;
          end else begin
            if (fall && !hi_seen_q) begin
              hi_cap_d  = cnt_q;
              hi_seen_d = 1'b1;
            end
            if (cnt_q == CNT_MAX) begin
              done        = 1'b1;
              done_period = CNT_MAX;
              done_ovf    = 1'b1;
              state_d     = ST_ARM;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and measurement registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      hi_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      hi_seen_q <= hi_seen_d;
    end
  end

  // Result hold register with valid/ready handshake and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q    <= '0;
      high_time_q <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      dropped_q   <= 1'b0;
    end else if (done) begin
      if (!valid_q || meas_ready) begin
        period_q    <= done_period;
        high_time_q <= done_high;
        overflow_q  <= done_ovf;
        valid_q     <= 1'b1;
      end else begin
        dropped_q <= 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign overflow   = overflow_q;
  assign meas_valid = valid_q;
  assign dropped    = dropped_q;

endmodule : pulse_capture

// File: tb/tb_pulse_capture.sv
// Directed testbench for pulse_capture (WIDTH=8, SYNC_STAGES=2).
// A background generator drives sig_in on the falling clock edge; outputs are
// sampled 1 ns after the rising edge. Edge numbers in comments count rising
// clock edges after the first sig_in rise of the current scenario.
module tb_pulse_capture;
  import pulse_capture_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             sig_in = 1'b0;
  logic             meas_ready;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             overflow;
  logic             meas_valid;
  logic             dropped;

  int checks = 0;
  int errors = 0;

  logic wave_on  = 1'b0;
  int   wave_per = 10;
  int   wave_hi  = 3;
  int   ph       = 0;

  pulse_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .overflow   (overflow),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  // Square-wave generator: high for wave_hi of every wave_per cycles,
  // starting high on the first falling edge after wave_on is set.
  always @(negedge clk) begin
    if (wave_on) begin
      sig_in = (ph < wave_hi);
      ph     = (ph + 1 == wave_per) ? 0 : ph + 1;
    end else begin
      sig_in = 1'b0;
      ph     = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    meas_ready = 1'b0;
    wave_on    = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    meas_ready = 1'b0;
    wave_on    = 1'b0;
    cycles(2);
    checks++;
    if ({period, high_time, overflow, meas_valid, dropped} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got p=%0d h=%0d o=%b v=%b d=%b want all 0",
               period, high_time, overflow, meas_valid, dropped);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d", dut.state_q, ST_IDLE);
    end
    reset_n = 1'b1;
    cycles(2);
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid got %b want 0", meas_valid);
    end
  endtask

  task automatic test_square();
    do_reset();
    meas_ready = 1'b1;
    enable     = 1'b1;
    cycles(2);
    wave_per = 10; wave_hi = 3; wave_on = 1'b1;
    cycles(13);                                    // E13
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL sq_early_valid got %b want 0", meas_valid);
    end
    cycles(1);                                     // E14: second rise + 4
    checks++;
    if (meas_valid !== 1'b1) begin
      errors++;
      $display("FAIL sq_first_valid got %b want 1", meas_valid);
    end
    checks++;
    if ({period, high_time, overflow, dropped} !== {8'd10, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sq_first_result got p=%0d h=%0d o=%b d=%b want p=10 h=3 o=0 d=0",
               period, high_time, overflow, dropped);
    end
    cycles(1);                                     // E15: accepted
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL sq_accept got %b want 0", meas_valid);
    end
    cycles(9);                                     // E24: next result
    checks++;
    if ({meas_valid, period, high_time, overflow} !== {1'b1, 8'd10, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL sq_second_result got v=%b p=%0d h=%0d o=%b want v=1 p=10 h=3 o=0",
               meas_valid, period, high_time, overflow);
    end
    wave_on = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1;
    cycles(2);
    wave_per = 10; wave_hi = 3; wave_on = 1'b1;
    cycles(14);                                    // E14: first result held
    checks++;
    if ({meas_valid, period, high_time} !== {1'b1, 8'd10, 8'd3}) begin
      errors++;
      $display("FAIL bp_first got v=%b p=%0d h=%0d want v=1 p=10 h=3",
               meas_valid, period, high_time);
    end
    cycles(6);                                     // E20: later pulses 5 high
    wave_hi = 5;
    cycles(5);                                     // E25: E24 result dropped
    checks++;
    if ({dropped, high_time} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL bp_drop got d=%b h=%0d want d=1 h=3", dropped, high_time);
    end
    cycles(15);                                    // E40: E34 result dropped too
    checks++;
    if ({meas_valid, dropped, period, high_time} !== {1'b1, 1'b1, 8'd10, 8'd3}) begin
      errors++;
      $display("FAIL bp_held got v=%b d=%b p=%0d h=%0d want v=1 d=1 p=10 h=3",
               meas_valid, dropped, period, high_time);
    end
    meas_ready = 1'b1;
    cycles(1);                                     // E41: accept
    checks++;
    if ({meas_valid, dropped} !== 2'b00) begin
      errors++;
      $display("FAIL bp_accept got v=%b d=%b want v=0 d=0", meas_valid, dropped);
    end
    cycles(3);                                     // E44: fresh result
    checks++;
    if ({meas_valid, dropped, period, high_time} !== {1'b1, 1'b0, 8'd10, 8'd5}) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%b p=%0d h=%0d want v=1 d=0 p=10 h=5",
               meas_valid, dropped, period, high_time);
    end
    wave_on = 1'b0;
  endtask

  task automatic test_overflow();
    int extra;
    do_reset();
    enable = 1'b1;
    cycles(2);
    wave_per = 1000; wave_hi = 5; wave_on = 1'b1;
    cycles(258);                                   // E258: cnt just reached 255
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early got %b want 0", meas_valid);
    end
    cycles(1);                                     // E259: saturation result
    checks++;
    if ({meas_valid, period, high_time, overflow} !== {1'b1, 8'd255, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL ovf_result got v=%b p=%0d h=%0d o=%b want v=1 p=255 h=5 o=1",
               meas_valid, period, high_time, overflow);
    end
    checks++;
    if (dut.state_q !== ST_ARM) begin
      errors++;
      $display("FAIL ovf_state got %0d want %0d", dut.state_q, ST_ARM);
    end
    meas_ready = 1'b1;
    cycles(1);
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      cycles(1);
      if (meas_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ovf_no_more got %0d valid cycles want 0", extra);
    end
    wave_on = 1'b0;
  endtask

  task automatic test_enable_abort();
    do_reset();
    enable = 1'b1;
    cycles(2);
    wave_per = 10; wave_hi = 3; wave_on = 1'b1;
    cycles(17);                                    // E17: result held since E14
    enable = 1'b0;
    cycles(1);                                     // E18
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL en_idle got %0d want %0d", dut.state_q, ST_IDLE);
    end
    checks++;
    if ({meas_valid, period, high_time, dropped} !== {1'b1, 8'd10, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL en_held got v=%b p=%0d h=%0d d=%b want v=1 p=10 h=3 d=0",
               meas_valid, period, high_time, dropped);
    end
    meas_ready = 1'b1;
    cycles(1);                                     // E19: accepted while idle
    enable = 1'b1;
    cycles(1);                                     // E20: re-armed
    wave_hi = 6;
    checks++;
    if (dut.state_q !== ST_ARM) begin
      errors++;
      $display("FAIL en_rearm got %0d want %0d", dut.state_q, ST_ARM);
    end
    cycles(4);                                     // E24: first new rise only arms
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_one_rise got %b want 0", meas_valid);
    end
    cycles(10);                                    // E34: second new rise
    checks++;
    if ({meas_valid, period, high_time, overflow} !== {1'b1, 8'd10, 8'd6, 1'b0}) begin
      errors++;
      $display("FAIL en_new_result got v=%b p=%0d h=%0d o=%b want v=1 p=10 h=6 o=0",
               meas_valid, period, high_time, overflow);
    end
    wave_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    cycles(2);
    wave_per = 4; wave_hi = 2; wave_on = 1'b1;
    cycles(8);                                     // E8: first result
    checks++;
    if ({meas_valid, period, high_time} !== {1'b1, 8'd4, 8'd2}) begin
      errors++;
      $display("FAIL b2b_first got v=%b p=%0d h=%0d want v=1 p=4 h=2",
               meas_valid, period, high_time);
    end
    for (int k = 0; k < 4; k++) begin
      cycles(3);
      meas_ready = 1'b1;                           // ready only on completion cycles
      cycles(1);
      meas_ready = 1'b0;
      checks++;
      if ({meas_valid, dropped, period, high_time, overflow} !==
          {1'b1, 1'b0, 8'd4, 8'd2, 1'b0}) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b d=%b p=%0d h=%0d o=%b want v=1 d=0 p=4 h=2 o=0",
                 k, meas_valid, dropped, period, high_time, overflow);
      end
    end
    wave_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    cycles(2);
    wave_per = 10; wave_hi = 3; wave_on = 1'b1;
    cycles(16);                                    // E16: held result, measuring
    checks++;
    if ({meas_valid, dut.state_q} !== {1'b1, ST_MEASURE}) begin
      errors++;
      $display("FAIL rst_pre got v=%b s=%0d want v=1 s=%0d",
               meas_valid, dut.state_q, ST_MEASURE);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({period, high_time, overflow, meas_valid, dropped} !== '0) begin
      errors++;
      $display("FAIL rst_async got p=%0d h=%0d o=%b v=%b d=%b want all 0",
               period, high_time, overflow, meas_valid, dropped);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_state got %0d want %0d", dut.state_q, ST_IDLE);
    end
    wave_on = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    meas_ready = 1'b0;
    test_reset();
    test_square();
    test_backpressure();
    test_overflow();
    test_enable_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_capture
